// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the RAM side of the memory arbiter, plus the
// constants used by the simulation/synthesis RAM model ram_responder.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Handshake presented by the RAM to the arbiter.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Word driven on ramload while the RAM sits in ERROR.
  localparam word_t RAM_ERR_WORD = 32'hBAD1BAD1;

  // Default number of BUSY wait cycles before ACCESS.
  localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// ram_array: 2^ADDR_W x 32 word storage for ram_responder.
// One synchronous write port and one asynchronous read port. The storage
// has no reset, so its contents survive the responder's nRST.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  word_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output word_t             o_rdata
);

  word_t r_mem [0:(1 << ADDR_W)-1];

  // Word-wide write, committed on the rising edge.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// ram_responder: far end of the arbiter's RAM request port.
// A request (ramREN xor ramWEN) is latched, waits LAT cycles in BUSY and is
// served for exactly one ACCESS cycle. A request that changes while waiting
// restarts the wait; REN and WEN together give ERROR.
// Optional feature, macro RAM_BOUNDS_CHECK_EN: requests with nonzero bits
// above the storage range or a misaligned byte address go to ERROR and stay
// there until the request drops or changes. Without it those bits are ignored.
// ramload is registered: it is computed from the next state and next latch.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT    = RAM_LAT_DEFAULT,
  parameter int ADDR_W = 14
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam logic [3:0] LAT_C = 4'(LAT);

  ramstate_t r_state;
  logic [3:0] r_cnt;
  logic       r_op;      // 1: write, 0: read
  word_t      r_addr;
  word_t      r_data;
  logic       r_bad;     // latched request failed the bounds check
  word_t      r_load;

  ramstate_t  w_nxt_state;
  ramstate_t  w_start_state;
  logic [3:0] w_nxt_cnt;
  logic       w_nxt_op;
  word_t      w_nxt_addr;
  word_t      w_nxt_data;
  logic       w_nxt_bad;
  word_t      w_nxt_load;
  logic       w_any;
  logic       w_both;
  logic       w_one;
  logic       w_changed;
  logic       w_bad;
  logic       w_we;
  word_t      w_rdata;

  assign w_any  = ramREN | ramWEN;
  assign w_both = ramREN & ramWEN;
  assign w_one  = ramREN ^ ramWEN;

  // Live request differs from the latch: op, address, or data of a write.
  assign w_changed = (ramWEN != r_op) || (ramaddr != r_addr) ||
                     (ramWEN && (ramstore != r_data));

`ifdef RAM_BOUNDS_CHECK_EN
  assign w_bad = (ramaddr[31:ADDR_W+2] != '0) || (ramaddr[1:0] != 2'b00);
`else
  assign w_bad = 1'b0;
`endif

  // Where a freshly latched request goes first.
  assign w_start_state = w_bad ? ERROR : ((LAT_C == 4'd0) ? ACCESS : BUSY);

  // Commit a write only when the live request still matches the latch.
  assign w_we = (r_state == ACCESS) && r_op && w_one && !w_changed;

  ram_array #(.ADDR_W(ADDR_W)) u_ram (
    .CLK     (CLK),
    .i_we    (w_we),
    .i_waddr (r_addr[ADDR_W+1:2]),
    .i_wdata (r_data),
    .i_raddr (w_nxt_addr[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

  // Next-state, counter and latch logic.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_op    = r_op;
    w_nxt_addr  = r_addr;
    w_nxt_data  = r_data;
    w_nxt_bad   = r_bad;
    case (r_state)
      FREE: begin
        if (w_both) begin
          w_nxt_state = ERROR;
          w_nxt_bad   = 1'b0;
        end else if (w_one) begin
          w_nxt_op    = ramWEN;
          w_nxt_addr  = ramaddr;
          w_nxt_data  = ramstore;
          w_nxt_bad   = w_bad;
          w_nxt_cnt   = LAT_C;
          w_nxt_state = w_start_state;
        end else begin
          w_nxt_state = FREE;
        end
      end
      BUSY, ACCESS: begin
        if (!w_any) begin
          // Request withdrawn: forget it.
          w_nxt_state = FREE;
          w_nxt_cnt   = 4'd0;
          w_nxt_op    = 1'b0;
          w_nxt_addr  = 32'h0;
          w_nxt_data  = 32'h0;
          w_nxt_bad   = 1'b0;
        end else if (w_both) begin
          w_nxt_state = ERROR;
          w_nxt_bad   = 1'b0;
        end else if (w_changed) begin
          // Stale request never reaches ACCESS: relatch and restart.
          w_nxt_op    = ramWEN;
          w_nxt_addr  = ramaddr;
          w_nxt_data  = ramstore;
          w_nxt_bad   = w_bad;
          w_nxt_cnt   = LAT_C;
          w_nxt_state = w_start_state;
        end else if (r_state == ACCESS) begin
          w_nxt_state = FREE;
        end else begin
          w_nxt_cnt   = r_cnt - 4'd1;
          w_nxt_state = (r_cnt <= 4'd1) ? ACCESS : BUSY;
        end
      end
      ERROR: begin
        if (w_both) begin
          w_nxt_state = ERROR;
        end else if (r_bad && w_one && !w_changed) begin
          w_nxt_state = ERROR;
        end else begin
          w_nxt_state = FREE;
          w_nxt_bad   = 1'b0;
        end
      end
      default: begin
        w_nxt_state = FREE;
      end
    endcase
  end

  // Output word for the coming cycle.
  always_comb begin
    w_nxt_load = 32'h0;
    case (w_nxt_state)
      ACCESS: begin
        if (!w_nxt_op) begin
          w_nxt_load = w_rdata;
        end else begin
          w_nxt_load = 32'h0;
        end
      end
      ERROR:   w_nxt_load = RAM_ERR_WORD;
      default: w_nxt_load = 32'h0;
    endcase
  end

  // State, counter, latch and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FREE;
      r_cnt   <= 4'd0;
      r_op    <= 1'b0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_bad   <= 1'b0;
      r_load  <= 32'h0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_op    <= w_nxt_op;
      r_addr  <= w_nxt_addr;
      r_data  <= w_nxt_data;
      r_bad   <= w_nxt_bad;
      r_load  <= w_nxt_load;
    end
  end

  assign ramstate = r_state;
  assign ramload  = r_load;

endmodule

// File: tb/tb_ram_responder.sv
// Testbench for ram_responder: a table of per-cycle vectors for the LAT=2
// instance, plus hand-written reset and LAT=0 sequences.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  logic      ren, wen;
  word_t     addr, store, load;
  ramstate_t st;

  logic      ren0, wen0;
  word_t     addr0, store0, load0;
  ramstate_t st0;

  int n_checks = 0;
  int n_fail   = 0;

  localparam word_t CAFE = 32'hCAFEF00D;
  localparam word_t W80  = 32'h12345678;
  localparam word_t W44  = 32'h44444444;
  localparam word_t BAD  = 32'hBAD1BAD1;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(2), .ADDR_W(14)) dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(store), .ramload(load), .ramstate(st)
  );

  ram_responder #(.LAT(0), .ADDR_W(14)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren0), .ramWEN(wen0),
    .ramaddr(addr0), .ramstore(store0), .ramload(load0), .ramstate(st0)
  );

  typedef struct {
    logic      r;
    logic      w;
    word_t     a;
    word_t     d;
    ramstate_t st;
    word_t     ld;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic w, input word_t a,
                              input word_t d, input ramstate_t s, input word_t l);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.st = s; v.ld = l;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    ren = 1'b0; wen = 1'b0; addr = 32'h0; store = 32'h0;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; store0 = 32'h0;

    // preload word 0x10
    add(0, 1, 32'h40, CAFE, FREE, 32'h0);
    add(0, 1, 32'h40, CAFE, BUSY, 32'h0);
    add(0, 1, 32'h40, CAFE, BUSY, 32'h0);
    add(0, 1, 32'h40, CAFE, ACCESS, 32'h0);
    // read latency
    add(1, 0, 32'h40, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h40, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h40, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h40, 32'h0, ACCESS, CAFE);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    // write then read 0x80, back to back
    add(0, 1, 32'h80, W80, FREE, 32'h0);
    add(0, 1, 32'h80, W80, BUSY, 32'h0);
    add(0, 1, 32'h80, W80, BUSY, 32'h0);
    add(0, 1, 32'h80, W80, ACCESS, 32'h0);
    add(1, 0, 32'h80, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h80, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h80, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h80, 32'h0, ACCESS, W80);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    // preload 0x44
    add(0, 1, 32'h44, W44, FREE, 32'h0);
    add(0, 1, 32'h44, W44, BUSY, 32'h0);
    add(0, 1, 32'h44, W44, BUSY, 32'h0);
    add(0, 1, 32'h44, W44, ACCESS, 32'h0);
    // address changed 0x40 -> 0x44 in first BUSY
    add(1, 0, 32'h40, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h44, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h44, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h44, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h44, 32'h0, ACCESS, W44);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    // write data changed during ACCESS, then dropped: no commit
    add(0, 1, 32'h80, 32'hAAAA0000, FREE, 32'h0);
    add(0, 1, 32'h80, 32'hAAAA0000, BUSY, 32'h0);
    add(0, 1, 32'h80, 32'hAAAA0000, BUSY, 32'h0);
    add(0, 1, 32'h80, 32'hBBBB0000, ACCESS, 32'h0);
    add(0, 0, 32'h0, 32'h0, BUSY, 32'h0);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h80, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h80, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h80, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h80, 32'h0, ACCESS, W80);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    // REN & WEN conflict, then WEN dropped
    add(1, 1, 32'h40, 32'h0, FREE, 32'h0);
    add(1, 1, 32'h40, 32'h0, ERROR, BAD);
    add(1, 0, 32'h40, 32'h0, ERROR, BAD);
    add(1, 0, 32'h40, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h40, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h40, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h40, 32'h0, ACCESS, CAFE);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    // REN dropped mid-BUSY
    add(1, 0, 32'h40, 32'h0, FREE, 32'h0);
    add(0, 0, 32'h0, 32'h0, BUSY, 32'h0);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
`ifdef RAM_BOUNDS_CHECK_EN
    add(1, 0, 32'h00010040, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h00010040, 32'h0, ERROR, BAD);
    add(1, 0, 32'h00010040, 32'h0, ERROR, BAD);
    add(1, 0, 32'h00010040, 32'h0, ERROR, BAD);
    add(0, 0, 32'h0, 32'h0, ERROR, BAD);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h42, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h42, 32'h0, ERROR, BAD);
    add(1, 0, 32'h42, 32'h0, ERROR, BAD);
    add(1, 0, 32'h42, 32'h0, ERROR, BAD);
    add(0, 0, 32'h0, 32'h0, ERROR, BAD);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
`else
    add(1, 0, 32'h00010040, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h00010040, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h00010040, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h00010040, 32'h0, ACCESS, CAFE);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h42, 32'h0, FREE, 32'h0);
    add(1, 0, 32'h42, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h42, 32'h0, BUSY, 32'h0);
    add(1, 0, 32'h42, 32'h0, ACCESS, CAFE);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
    add(0, 0, 32'h0, 32'h0, FREE, 32'h0);
`endif

    // reset state
    #12;
    nRST = 1'b1;
    #1;
    check("reset state", 32'(st), 32'(FREE));
    check("reset load", load, 32'h0);
    check("reset state lat0", 32'(st0), 32'(FREE));
    check("reset load lat0", load0, 32'h0);

    // table-driven per-cycle vectors on the LAT=2 instance
    for (int i = 0; i < vecs.size(); i++) begin
      step();
      ren = vecs[i].r; wen = vecs[i].w; addr = vecs[i].a; store = vecs[i].d;
      @(negedge CLK);
      check($sformatf("vec%0d state", i), 32'(st), 32'(vecs[i].st));
      check($sformatf("vec%0d load", i), load, vecs[i].ld);
    end

    // reset during a write's BUSY: immediate FREE, no commit
    step();
    ren = 1'b0; wen = 1'b1; addr = 32'h80; store = 32'hDEADBEEF;
    @(negedge CLK);
    check("rst seq free", 32'(st), 32'(FREE));
    step();
    check("rst seq busy", 32'(st), 32'(BUSY));
    #2;
    nRST = 1'b0;
    #1;
    check("rst async state", 32'(st), 32'(FREE));
    check("rst async load", load, 32'h0);
    wen = 1'b0; addr = 32'h0; store = 32'h0;
    @(negedge CLK);
    nRST = 1'b1;
    step();
    ren = 1'b1; addr = 32'h80;
    step();
    step();
    step();
    @(negedge CLK);
    check("rst no commit state", 32'(st), 32'(ACCESS));
    check("rst no commit data", load, W80);
    step();
    ren = 1'b0; addr = 32'h0;

    // LAT=0: write then read reach ACCESS in cycle 1
    step();
    wen0 = 1'b1; addr0 = 32'h10; store0 = 32'h0F0F0F0F;
    @(negedge CLK);
    check("lat0 wr free", 32'(st0), 32'(FREE));
    step();
    @(negedge CLK);
    check("lat0 wr access", 32'(st0), 32'(ACCESS));
    step();
    wen0 = 1'b0; ren0 = 1'b1;
    @(negedge CLK);
    check("lat0 rd free", 32'(st0), 32'(FREE));
    step();
    @(negedge CLK);
    check("lat0 rd access", 32'(st0), 32'(ACCESS));
    check("lat0 rd data", load0, 32'h0F0F0F0F);
    step();
    ren0 = 1'b0; addr0 = 32'h0;
    @(negedge CLK);
    check("lat0 back free", 32'(st0), 32'(FREE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Word-addressed RAM that answers the arbiter's RAM-side request port (`ramREN`/`ramWEN`/`ramaddr`/`ramstore`) with a `ramstate` handshake and `ramload` data. Every access takes a parameterised number of wait cycles. The arbiter holds a request steady until it sees `ACCESS`, then releases its requester. This block is the far end of that protocol. It serves as the system RAM for simulation and synthesis of the single-cycle CPU.

## Interface
Parameters:
- `LAT`, 2: wait cycles spent in `BUSY` before `ACCESS`. Legal range 0–15.
- `ADDR_W`, 14: word-index width. Storage depth is 2^ADDR_W words.

Ports:
- `CLK`, input, 1: clock. Rising edge.
- `nRST`, input, 1: asynchronous active-low reset.
- `ramREN`, input, 1: read request, held until `ACCESS`.
- `ramWEN`, input, 1: write request, held until `ACCESS`.
- `ramaddr`, input, 32: byte address. Word index is `ramaddr[ADDR_W+1:2]`.
- `ramstore`, input, 32: write data.
- `ramload`, output, 32: read data. Valid only while `ramstate==ACCESS` on a read.
- `ramstate`, output, `ramstate_t`: one of `FREE`, `BUSY`, `ACCESS`, `ERROR`. Registered.

## Operation
- Registered state: `ramstate`, countdown `cnt`, and a latch holding `{op, addr, data}`.
- **FREE**
  - Exactly one of REN/WEN asserted: latch the request and load `cnt<=LAT`. Next state is `BUSY`, or `ACCESS` if `LAT==0`.
  - REN and WEN both asserted: next state `ERROR`.
  - Neither asserted: stay in `FREE`.
- **BUSY**
  - Request dropped (REN=WEN=0): go to `FREE` and discard the latch.
  - Request changed (op, addr, or `ramstore` while writing differs from latch): relatch, reload `cnt<=LAT`, restart the wait.
  - REN and WEN both asserted: go to `ERROR`.
  - Otherwise decrement `cnt`. When `cnt==1`, next state is `ACCESS`.
- **ACCESS** (exactly one cycle)
  - Read: `ramload = mem[latched index]`.
  - Write: storage commits `latched data` at the edge ending `ACCESS`, but only if the live inputs still match the latch.
  - Mismatch: no commit, and the request is handled as a changed request (relatch, restart).
  - Otherwise next state is `FREE`.
- **ERROR**
  - `ramload = RAM_ERR_WORD` (32'hBAD1BAD1).
  - Leave to `FREE` once REN&WEN is no longer asserted.
- Outside `ACCESS`/`ERROR`, `ramload = 32'h0`.
- Writes are word-wide only; there are no byte enables.
- A read in the cycle after a write to the same word returns the new data.

## Timing
- Request first visible in cycle 0 (state `FREE`). `ACCESS` is presented in cycle `LAT+1`.
- Back-to-back requests: `ACCESS` → `FREE` (the new request is latched in `FREE`) → … Each access therefore costs `LAT+2` cycles.
- Reset values: `ramstate=FREE`, `cnt=0`, latch=0, `ramload=0`.
- Reset mid-access abandons the access and performs no write. Storage contents are unaffected by `nRST` and are zero at time 0.
- A request changed in the same cycle it would reach `ACCESS` restarts the wait; `ACCESS` is not issued for the stale request.

## Configuration
- `RAM_BOUNDS_CHECK_EN` defined: a request whose `ramaddr[31:ADDR_W+2]` is nonzero, or whose `ramaddr[1:0]` is nonzero, sends the block to `ERROR` from `FREE`/`BUSY` instead of `BUSY`/`ACCESS`. It stays there until the request drops or changes.
- Undefined: the upper and low address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) and are truncated to word alignment.

## Structure
- Use `ramstate_t` and `word_t` from `cpu_types_pkg`.
- Add `RAM_ERR_WORD` and `RAM_LAT_DEFAULT` to that package.
- Sub-module `ram_array`: 2^ADDR_W × 32 storage with one synchronous write port and one asynchronous read port, and no reset.
- `ram_responder` holds the FSM, counter, latch and compare logic.

## Test plan
- **Read latency.** `LAT=2`, preload word 0x10 = 32'hCAFEF00D, hold REN with addr 0x40 → `ramstate` is `FREE`, `BUSY`, `BUSY`, `ACCESS` with `ramload`=32'hCAFEF00D in cycle 3, then `FREE`.
- **Write then read.** Write 32'h12345678 to 0x80, then read 0x80 → the read `ACCESS` returns 32'h12345678.
- **Changed request.** Change addr 0x40→0x44 in the first `BUSY` cycle → `cnt` restarts; `ACCESS` arrives 2 `BUSY` cycles after the change, with data from 0x44. Write data changed during `ACCESS` → no commit, wait restarts.
- **Conflict and drop.** REN&WEN together → `ERROR`, `ramload`=32'hBAD1BAD1; drop WEN → `FREE`, then the normal read proceeds. Drop REN mid-`BUSY` → `FREE`, no `ACCESS`.
- **Reset and LAT=0.** Assert `nRST` low during a write's `BUSY` → `ramstate=FREE` immediately and the target word is unchanged. With `LAT=0`, a read reaches `ACCESS` in cycle 1.
- **Bounds check.** With `RAM_BOUNDS_CHECK_EN`, addr 0x0001_0000 (ADDR_W=14) or 0x42 → `ERROR`. Without the macro, 0x0001_0040 aliases to word 0x10.
